slink_tx_credit_scheduler: RTL and testbench

SLINK_TX_CREDIT_SCHEDULER -- requirements
Module: slink_tx_credit_scheduler

---
 rtl/slink_tx_credit_scheduler_pkg.sv | 35 +++
 rtl/slink_demet_reset.sv | 33 +++
 rtl/slink_tx_credit_scheduler.sv | 176 +++++++++++++++++
 tb/tb_slink_tx_credit_scheduler.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slink_tx_credit_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// slink_tx_credit_scheduler_pkg
// Shared TX scheduling definitions for the slink transmit path:
//   - sched_state_t : scheduler FSM state encoding
//   - beat_count()  : payload byte count -> link beat count
// ---------------------------------------------------------------------------
package slink_tx_credit_scheduler_pkg;

    typedef enum logic [0:0] {
        SCHED_IDLE = 1'b0,
        SCHED_BUSY = 1'b1
    } sched_state_t;

    localparam int WORD_COUNT_WIDTH = 16;
    // One bit wider than the byte count so that 0xFFFF rounded up cannot wrap.
    localparam int BEAT_COUNT_WIDTH = 17;

    // Number of link beats needed to carry word_count payload bytes.
    // A zero-length packet still occupies one beat on the link.
    function automatic logic [BEAT_COUNT_WIDTH-1:0] beat_count(
        input logic [WORD_COUNT_WIDTH-1:0] word_count,
        input int                          bytes_per_beat
    );
        logic [BEAT_COUNT_WIDTH-1:0] wc_ext;
        logic [BEAT_COUNT_WIDTH-1:0] beats;
        wc_ext = {1'b0, word_count};
        beats  = (wc_ext + BEAT_COUNT_WIDTH'(bytes_per_beat - 1))
                 / BEAT_COUNT_WIDTH'(bytes_per_beat);
        if (beats == '0) begin
            beats = BEAT_COUNT_WIDTH'(1);
        end
        return beats;
    endfunction

endpackage

// File: rtl/slink_demet_reset.sv
// ---------------------------------------------------------------------------
// slink_demet_reset
// Two-flop synchronizer for a single asynchronous level into the clk domain.
// Both flops clear on reset, so the synchronized output is 0 out of reset.
// Ports:
//   clk      : destination clock
//   reset    : asynchronous, active-high
//   sig_in   : asynchronous input level
//   sig_out  : synchronized level (two clk cycles of latency)
// ---------------------------------------------------------------------------
module slink_demet_reset (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic sig_out
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= sig_in;
            sync_reg <= meta_reg;
        end
    end

    assign sig_out = sync_reg;

endmodule

// File: rtl/slink_tx_credit_scheduler.sv
// ---------------------------------------------------------------------------
// slink_tx_credit_scheduler
// Credit-based round-robin packet scheduler for the slink TX path. Each
// channel holds a credit counter; a requesting channel with credit can win
// the link, which then stays granted until all its beats are accepted.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   enable              : asynchronous scheduler enable (synchronized here)
//   tx_sop_ch           : per-channel packet request, held until granted
//   tx_word_count_ch    : per-channel payload byte count (16 bits each)
//   credit_return_ch    : per-channel one-cycle credit return pulse
//   tx_advance          : link accepted one beat of the granted channel
//   grant_ch/grant_idx  : registered one-hot grant and its index
//   busy                : a packet is in flight
//   pkt_done            : pulse on the cycle after the final beat
//   credit_count_ch     : current credit counters (CREDIT_WIDTH each)
// ---------------------------------------------------------------------------
module slink_tx_credit_scheduler
    import slink_tx_credit_scheduler_pkg::*;
#(
    parameter int NUM_CHANNELS      = 8,
    parameter int TX_APP_DATA_WIDTH = 64,
    parameter int CREDIT_WIDTH      = 4,
    parameter int INIT_CREDITS      = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic [NUM_CHANNELS-1:0]              tx_sop_ch,
    input  logic [NUM_CHANNELS*16-1:0]           tx_word_count_ch,
    input  logic [NUM_CHANNELS-1:0]              credit_return_ch,
    input  logic                                 tx_advance,
    output logic [NUM_CHANNELS-1:0]              grant_ch,
    output logic [$clog2(NUM_CHANNELS)-1:0]      grant_idx,
    output logic                                 busy,
    output logic                                 pkt_done,
    output logic [NUM_CHANNELS*CREDIT_WIDTH-1:0] credit_count_ch
);

    localparam int IDX_W          = $clog2(NUM_CHANNELS);
    localparam int BYTES_PER_BEAT = TX_APP_DATA_WIDTH / 8;

    sched_state_t                state_reg;
    logic [NUM_CHANNELS-1:0]     grant_ch_reg;
    logic [IDX_W-1:0]            grant_idx_reg;
    logic                        busy_reg;
    logic                        pkt_done_reg;
    logic [IDX_W-1:0]            rr_ptr_reg;
    logic [BEAT_COUNT_WIDTH-1:0] beats_left_reg;

    logic                        enable_sync;
    logic [NUM_CHANNELS-1:0]     eligible_vec;
    logic [NUM_CHANNELS-1:0]     win_onehot;
    logic                        win_found;
    logic [IDX_W-1:0]            win_idx;
    logic                        start_grant;
    logic [WORD_COUNT_WIDTH-1:0] win_word_count;

    slink_demet_reset u_enable_sync (
        .clk     (clk),
        .reset   (reset),
        .sig_in  (enable),
        .sig_out (enable_sync)
    );

    // Round-robin pick: scan from rr_ptr upward with wrap, first eligible wins.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            cand     = (int'(rr_ptr_reg) + k) % NUM_CHANNELS;
            cand_idx = IDX_W'(cand);
            if (!win_found && eligible_vec[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // A grant only starts from IDLE, so the pkt_done cycle is always idle.
    assign start_grant    = (state_reg == SCHED_IDLE) && win_found;
    assign win_word_count = tx_word_count_ch[16*int'(win_idx) +: 16];

    // Per-channel credit counters and eligibility.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
            logic [CREDIT_WIDTH-1:0] credit_reg;
            logic [CREDIT_WIDTH-1:0] credit_next;
            logic                    consume;

            assign win_onehot[gi]   = (win_idx == IDX_W'(gi));
            assign consume          = start_grant && win_onehot[gi];
            assign eligible_vec[gi] = tx_sop_ch[gi] && (credit_reg != '0) && enable_sync;

            // Consume and return in the same cycle cancel out. Consume never
            // underflows because only channels with credit are eligible.
            always_comb begin
                credit_next = credit_reg;
                if (consume && !credit_return_ch[gi]) begin
                    credit_next = credit_reg - 1'b1;
                end else if (!consume && credit_return_ch[gi] &&
                             (credit_reg != {CREDIT_WIDTH{1'b1}})) begin
                    credit_next = credit_reg + 1'b1;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    credit_reg <= CREDIT_WIDTH'(INIT_CREDITS);
                end else begin
                    credit_reg <= credit_next;
                end
            end

            assign credit_count_ch[gi*CREDIT_WIDTH +: CREDIT_WIDTH] = credit_reg;
        end
    endgenerate

    // Scheduler FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= SCHED_IDLE;
            grant_ch_reg   <= '0;
            grant_idx_reg  <= '0;
            busy_reg       <= 1'b0;
            pkt_done_reg   <= 1'b0;
            rr_ptr_reg     <= '0;
            beats_left_reg <= '0;
        end else begin
            pkt_done_reg <= 1'b0;
            case (state_reg)
                SCHED_IDLE: begin
                    if (start_grant) begin
                        state_reg      <= SCHED_BUSY;
                        grant_ch_reg   <= win_onehot;
                        grant_idx_reg  <= win_idx;
                        busy_reg       <= 1'b1;
                        beats_left_reg <= beat_count(win_word_count, BYTES_PER_BEAT);
                    end
                end
                SCHED_BUSY: begin
                    // Requests and enable are not consulted here: a granted
                    // packet always runs to completion.
                    if (tx_advance) begin
                        if (beats_left_reg == BEAT_COUNT_WIDTH'(1)) begin
                            state_reg      <= SCHED_IDLE;
                            grant_ch_reg   <= '0;
                            grant_idx_reg  <= '0;
                            busy_reg       <= 1'b0;
                            pkt_done_reg   <= 1'b1;
                            beats_left_reg <= '0;
                            rr_ptr_reg     <= (grant_idx_reg == IDX_W'(NUM_CHANNELS-1))
                                              ? '0 : grant_idx_reg + 1'b1;
                        end else begin
                            beats_left_reg <= beats_left_reg - 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= SCHED_IDLE;
                end
            endcase
        end
    end

    assign grant_ch  = grant_ch_reg;
    assign grant_idx = grant_idx_reg;
    assign busy      = busy_reg;
    assign pkt_done  = pkt_done_reg;

endmodule

// File: tb/tb_slink_tx_credit_scheduler.sv
// ---------------------------------------------------------------------------
// tb_slink_tx_credit_scheduler
// Directed bench: a table of single-packet vectors (channel, byte count,
// expected beats) followed by hand-written multi-cycle sequences for
// round-robin order, credit exhaustion, saturation, enable drop and reset.
// ---------------------------------------------------------------------------
module tb_slink_tx_credit_scheduler;

    localparam int NCH  = 4;
    localparam int DW   = 64;
    localparam int CW   = 4;
    localparam int INIT = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [NCH-1:0]    tx_sop_ch;
    logic [NCH*16-1:0] tx_word_count_ch;
    logic [NCH-1:0]    credit_return_ch;
    logic              tx_advance;
    logic [NCH-1:0]    grant_ch;
    logic [1:0]        grant_idx;
    logic              busy;
    logic              pkt_done;
    logic [NCH*CW-1:0] credit_count_ch;

    int checks = 0;
    int errors = 0;
    int credit_model [NCH];

    typedef struct {
        int ch;
        int word_count;
        int exp_beats;
    } pkt_vec_t;

    pkt_vec_t vecs [8];

    always #5 clk = ~clk;

    slink_tx_credit_scheduler #(
        .NUM_CHANNELS      (NCH),
        .TX_APP_DATA_WIDTH (DW),
        .CREDIT_WIDTH      (CW),
        .INIT_CREDITS      (INIT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .tx_sop_ch        (tx_sop_ch),
        .tx_word_count_ch (tx_word_count_ch),
        .credit_return_ch (credit_return_ch),
        .tx_advance       (tx_advance),
        .grant_ch         (grant_ch),
        .grant_idx        (grant_idx),
        .busy             (busy),
        .pkt_done         (pkt_done),
        .credit_count_ch  (credit_count_ch)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int credit_of(input int ch);
        return int'(credit_count_ch[ch*CW +: CW]);
    endfunction

    task automatic check_credits(input string name);
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("%s credit%0d", name, c), 64'(credit_of(c)), 64'(credit_model[c]));
        end
    endtask

    task automatic return_credit(input int ch);
        credit_return_ch[ch] = 1'b1;
        tick();
        credit_return_ch = '0;
        if (credit_model[ch] < 15) credit_model[ch]++;
        check($sformatf("return ch%0d credit", ch), 64'(credit_of(ch)), 64'(credit_model[ch]));
    endtask

    // Request one packet on ch with tx_advance every cycle; checks 1-cycle
    // grant latency, grant outputs, credit consumption, beat count and pkt_done.
    task automatic run_packet(input int ch, input int wc, input int exp_beats);
        int  n;
        bit  done;
        tx_word_count_ch[ch*16 +: 16] = 16'(wc);
        tx_sop_ch[ch] = 1'b1;
        tick();
        check($sformatf("pkt ch%0d busy", ch), 64'(busy), 64'd1);
        check($sformatf("pkt ch%0d grant_idx", ch), 64'(grant_idx), 64'(ch));
        check($sformatf("pkt ch%0d grant_ch", ch), 64'(grant_ch), 64'(1 << ch));
        credit_model[ch]--;
        check($sformatf("pkt ch%0d credit", ch), 64'(credit_of(ch)), 64'(credit_model[ch]));
        tx_sop_ch[ch] = 1'b0;
        tx_advance    = 1'b1;
        n    = 0;
        done = 1'b0;
        for (int i = 0; i < exp_beats + 4 && !done; i++) begin
            tick();
            n++;
            if (!busy) done = 1'b1;
        end
        tx_advance = 1'b0;
        check($sformatf("pkt ch%0d beats", ch), 64'(n), 64'(exp_beats));
        check($sformatf("pkt ch%0d pkt_done", ch), 64'(pkt_done), 64'd1);
        check($sformatf("pkt ch%0d grant_clear", ch), 64'({grant_ch, grant_idx}), 64'd0);
        tick();
        check($sformatf("pkt ch%0d pkt_done_pulse", ch), 64'(pkt_done), 64'd0);
        $display("pkt ch=%0d wc=%0d beats=%0d exp=%0d", ch, wc, n, exp_beats);
    endtask

    initial begin
        int order [4];
        int n_order;
        int n;
        bit prev_busy;
        bit prev_done;
        bit done;
        int busy_seen;

        vecs[0] = '{ch: 1, word_count: 20,        exp_beats: 3};
        vecs[1] = '{ch: 0, word_count: 0,         exp_beats: 1};
        vecs[2] = '{ch: 2, word_count: 1,         exp_beats: 1};
        vecs[3] = '{ch: 3, word_count: 8,         exp_beats: 1};
        vecs[4] = '{ch: 0, word_count: 9,         exp_beats: 2};
        vecs[5] = '{ch: 2, word_count: 64,        exp_beats: 8};
        vecs[6] = '{ch: 1, word_count: 'hFFFF,    exp_beats: 8192};
        vecs[7] = '{ch: 3, word_count: 65,        exp_beats: 9};

        reset            = 1'b0;
        enable           = 1'b1;
        tx_sop_ch        = '0;
        tx_word_count_ch = '0;
        credit_return_ch = '0;
        tx_advance       = 1'b0;
        for (int c = 0; c < NCH; c++) credit_model[c] = INIT;

        // Reset state, observed before any clock edge.
        #2 reset = 1'b1;
        #1;
        check("reset grant_ch", 64'(grant_ch), 64'd0);
        check("reset grant_idx", 64'(grant_idx), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset pkt_done", 64'(pkt_done), 64'd0);
        check_credits("reset");
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("post-reset idle busy", 64'(busy), 64'd0);

        // Table of single packets, credit returned after each one.
        for (int v = 0; v < 8; v++) begin
            run_packet(vecs[v].ch, vecs[v].word_count, vecs[v].exp_beats);
            return_credit(vecs[v].ch);
        end
        check_credits("table end");

        // Round robin: ch0, ch2, ch3 request together; rr_ptr is 0 here.
        tx_word_count_ch = {4{16'd8}};
        tx_sop_ch        = 4'b1101;
        tx_advance       = 1'b1;
        n_order   = 0;
        prev_busy = 1'b0;
        prev_done = 1'b0;
        for (int k = 0; k < 4; k++) order[k] = -1;
        for (int i = 0; i < 40 && n_order < 4; i++) begin
            tick();
            if (busy && !prev_busy) begin
                order[n_order] = int'(grant_idx);
                if (n_order > 0) begin
                    check($sformatf("rr gap before grant %0d", n_order), 64'(prev_done), 64'd1);
                end
                n_order++;
                if (n_order == 4) tx_sop_ch = '0;
            end
            prev_busy = busy;
            prev_done = pkt_done;
        end
        tick();
        tx_advance = 1'b0;
        check("rr final pkt_done", 64'(pkt_done), 64'd1);
        check("rr grant 0", 64'(order[0]), 64'd0);
        check("rr grant 1", 64'(order[1]), 64'd2);
        check("rr grant 2", 64'(order[2]), 64'd3);
        check("rr grant 3", 64'(order[3]), 64'd0);
        $display("rr order %0d %0d %0d %0d", order[0], order[1], order[2], order[3]);
        credit_model[0] -= 2;
        credit_model[2] -= 1;
        credit_model[3] -= 1;
        check_credits("rr after");
        credit_return_ch = 4'b1101;
        tick();
        credit_return_ch = 4'b0001;
        tick();
        credit_return_ch = '0;
        for (int c = 0; c < NCH; c++) credit_model[c] = INIT;
        check_credits("rr restored");

        // Credit exhaustion on ch2, then a single return unblocks it.
        run_packet(2, 8, 1);
        run_packet(2, 16, 2);
        check("exhaust credit2", 64'(credit_of(2)), 64'd0);
        tx_word_count_ch[2*16 +: 16] = 16'd8;
        tx_sop_ch[2] = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy) busy_seen++;
        end
        check("exhaust no grant", 64'(busy_seen), 64'd0);
        credit_return_ch[2] = 1'b1;
        tick();
        credit_return_ch = '0;
        check("exhaust returned credit2", 64'(credit_of(2)), 64'd1);
        check("exhaust still idle", 64'(busy), 64'd0);
        tick();
        check("exhaust regrant busy", 64'(busy), 64'd1);
        check("exhaust regrant idx", 64'(grant_idx), 64'd2);
        check("exhaust regrant credit2", 64'(credit_of(2)), 64'd0);
        tx_sop_ch  = '0;
        tx_advance = 1'b1;
        tick();
        tx_advance = 1'b0;
        check("exhaust regrant pkt_done", 64'(pkt_done), 64'd1);
        $display("exhaust ch2 regranted after return");
        tick();
        credit_model[2] = 0;
        return_credit(2);
        return_credit(2);

        // Saturation on ch1, then return coincident with a grant.
        credit_return_ch[1] = 1'b1;
        for (int i = 0; i < 13; i++) tick();
        credit_return_ch = '0;
        credit_model[1] = 15;
        check("sat credit1 at max", 64'(credit_of(1)), 64'd15);
        return_credit(1);
        check("sat credit1 held", 64'(credit_of(1)), 64'd15);
        tx_word_count_ch[1*16 +: 16] = 16'd8;
        tx_sop_ch[1]        = 1'b1;
        credit_return_ch[1] = 1'b1;
        tick();
        credit_return_ch = '0;
        tx_sop_ch        = '0;
        check("coincident busy", 64'(busy), 64'd1);
        check("coincident idx", 64'(grant_idx), 64'd1);
        check("coincident credit1", 64'(credit_of(1)), 64'd15);
        tx_advance = 1'b1;
        tick();
        tx_advance = 1'b0;
        check("coincident pkt_done", 64'(pkt_done), 64'd1);
        $display("saturate ch1 credit=%0d", credit_of(1));
        tick();

        // Enable dropped mid-packet: packet completes, no further grants.
        tx_word_count_ch[3*16 +: 16] = 16'd64;
        tx_sop_ch[3] = 1'b1;
        tick();
        check("endrop busy", 64'(busy), 64'd1);
        check("endrop idx", 64'(grant_idx), 64'd3);
        credit_model[3]--;
        tx_advance = 1'b1;
        tick();
        tick();
        enable = 1'b0;
        tx_word_count_ch[0*16 +: 16] = 16'd8;
        tx_sop_ch[0] = 1'b1;
        n    = 2;
        done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            tick();
            n++;
            if (!busy) done = 1'b1;
        end
        tx_advance = 1'b0;
        check("endrop beats", 64'(n), 64'd8);
        check("endrop pkt_done", 64'(pkt_done), 64'd1);
        busy_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy) busy_seen++;
        end
        check("endrop no grant", 64'(busy_seen), 64'd0);
        enable = 1'b1;
        done   = 1'b0;
        for (int i = 0; i < 6 && !done; i++) begin
            tick();
            if (busy) done = 1'b1;
        end
        check("reenable busy", 64'(busy), 64'd1);
        check("reenable idx", 64'(grant_idx), 64'd0);
        credit_model[0]--;
        tx_sop_ch  = '0;
        tx_advance = 1'b1;
        tick();
        tx_advance = 1'b0;
        check("reenable pkt_done", 64'(pkt_done), 64'd1);
        check_credits("reenable");
        $display("enable drop: ch3 packet beats=%0d, then ch0 granted", n);
        tick();

        // Reset during beat 2 of a multi-beat packet.
        tx_word_count_ch[0*16 +: 16] = 16'd64;
        tx_sop_ch[0] = 1'b1;
        tick();
        check("rstmid busy", 64'(busy), 64'd1);
        tx_sop_ch  = '0;
        tx_advance = 1'b1;
        tick();
        reset = 1'b1;
        #1;
        check("rstmid grant_ch", 64'(grant_ch), 64'd0);
        check("rstmid grant_idx", 64'(grant_idx), 64'd0);
        check("rstmid busy0", 64'(busy), 64'd0);
        check("rstmid pkt_done", 64'(pkt_done), 64'd0);
        for (int c = 0; c < NCH; c++) credit_model[c] = INIT;
        check_credits("rstmid");
        tx_advance = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (pkt_done || busy) busy_seen++;
        end
        check("rstmid no pkt_done", 64'(busy_seen), 64'd0);
        $display("reset mid-packet: outputs cleared, credits reloaded");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
